// File: rtl/pe_rr_arbiter8.sv
// 8-requester arbiter: rotated 8-to-3 priority encode, grant held until done, request drop or hold timeout.
// Latency 1 clk from req to grant; all outputs are flops; one forced idle cycle between tenures.
module pe_rr_arbiter8 #(
   parameter int unsigned RR_EN    = 1,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant,
   output logic [2:0] grant_id,
   output logic       grant_valid,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
   localparam bit         HOLD_EN    = (MAX_HOLD != 0);

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] grant_q, grant_d;
   logic [2:0] gid_q, gid_d;
   logic       gvld_q, gvld_d;
   logic       tmo_q, tmo_d;

   logic [2:0] base;
   logic [2:0] rot_idx;
   logic [2:0] win_off;
   logic [2:0] win_idx;
   logic [7:0] req_rot;
   logic       rel_done, rel_drop, rel_hold;

   // Rotate so that ptr-1 lands on bit 7, then a plain highest-bit-wins encode.
   always_comb begin
      base    = (RR_EN != 0) ? ptr_q : 3'd0;
      rot_idx = '0;
      req_rot = '0;
      win_off = '0;
      for (int k = 0; k < 8; k++) begin
         rot_idx    = base + 3'(k);
         req_rot[k] = req[rot_idx];
      end
      for (int k = 0; k < 8; k++) begin
         if (req_rot[k]) win_off = 3'(k);
      end
      win_idx = base + win_off;
   end

   always_comb begin
      rel_done = done;
      rel_drop = ~req[gid_q];
      rel_hold = HOLD_EN && (cnt_q == MAX_HOLD_C);

      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      gid_d   = gid_q;
      gvld_d  = gvld_q;
      tmo_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               grant_d = 8'b1 << win_idx;
               gid_d   = win_idx;
               gvld_d  = 1'b1;
               cnt_d   = 8'd1;
            end
         end
         GRANT: begin
            if (rel_done || rel_drop || rel_hold) begin
               state_d = IDLE;
               grant_d = '0;
               gvld_d  = 1'b0;
               ptr_d   = gid_q;
               cnt_d   = '0;
               // Timeout only when the hold limit alone ended the tenure.
               tmo_d   = rel_hold && !rel_done && !rel_drop;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         gid_q   <= '0;
         gvld_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         gid_q   <= gid_d;
         gvld_q  <= gvld_d;
         tmo_q   <= tmo_d;
      end
   end

   assign grant       = grant_q;
   assign grant_id    = gid_q;
   assign grant_valid = gvld_q;
   assign timeout     = tmo_q;

endmodule

// File: tb/tb_pe_rr_arbiter8.sv
// Directed bench for pe_rr_arbiter8: three instances (round-robin, fixed priority, short hold) share stimulus.
module tb_pe_rr_arbiter8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;

   logic [7:0] rr_grant, fp_grant, mh_grant;
   logic [2:0] rr_id, fp_id, mh_id;
   logic       rr_vld, fp_vld, mh_vld;
   logic       rr_tmo, fp_tmo, mh_tmo;

   int n_chk  = 0;
   int n_fail = 0;

   pe_rr_arbiter8 #(.RR_EN(1), .MAX_HOLD(16)) u_rr (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(rr_grant), .grant_id(rr_id), .grant_valid(rr_vld), .timeout(rr_tmo)
   );

   pe_rr_arbiter8 #(.RR_EN(0), .MAX_HOLD(16)) u_fp (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(fp_grant), .grant_id(fp_id), .grant_valid(fp_vld), .timeout(fp_tmo)
   );

   pe_rr_arbiter8 #(.RR_EN(1), .MAX_HOLD(4)) u_mh (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(mh_grant), .grant_id(mh_id), .grant_valid(mh_vld), .timeout(mh_tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req  = 8'h00;
      done = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      #12;
      check("rst_grant", rr_grant, 8'h00);
      check("rst_id", {5'd0, rr_id}, 8'd0);
      check("rst_vld", {7'd0, rr_vld}, 8'd0);
      check("rst_tmo", {7'd0, rr_tmo}, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      // Round robin over 8'hA4: 7, 5, 2, 7 with one idle cycle between tenures.
      req = 8'hA4;
      tick();
      check("rr1_grant", rr_grant, 8'h80);
      check("rr1_id", {5'd0, rr_id}, 8'd7);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rr1_gap_vld", {7'd0, rr_vld}, 8'd0);
      check("rr1_gap_grant", rr_grant, 8'h00);
      check("rr1_gap_tmo", {7'd0, rr_tmo}, 8'd0);
      tick();
      check("rr2_id", {5'd0, rr_id}, 8'd5);
      check("rr2_grant", rr_grant, 8'h20);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rr2_gap_vld", {7'd0, rr_vld}, 8'd0);
      tick();
      check("rr3_id", {5'd0, rr_id}, 8'd2);
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      check("rr4_id", {5'd0, rr_id}, 8'd7);
      check("rr4_vld", {7'd0, rr_vld}, 8'd1);

      // Fixed priority, all requesting: always 7.
      do_reset();
      req = 8'hFF;
      for (int t = 0; t < 3; t++) begin
         tick();
         check("fp_grant", fp_grant, 8'h80);
         check("fp_id", {5'd0, fp_id}, 8'd7);
         tick();
         check("fp_hold", fp_grant, 8'h80);
         done = 1'b1;
         tick();
         done = 1'b0;
         check("fp_gap_vld", {7'd0, fp_vld}, 8'd0);
         check("fp_gap_tmo", {7'd0, fp_tmo}, 8'd0);
      end

      // MAX_HOLD=4: four grant cycles, then a timeout cycle, then re-grant.
      do_reset();
      req = 8'h02;
      for (int t = 0; t < 4; t++) begin
         tick();
         check("mh_grant", mh_grant, 8'h02);
         check("mh_no_tmo", {7'd0, mh_tmo}, 8'd0);
      end
      tick();
      check("mh_rel_grant", mh_grant, 8'h00);
      check("mh_rel_vld", {7'd0, mh_vld}, 8'd0);
      check("mh_tmo", {7'd0, mh_tmo}, 8'd1);
      tick();
      check("mh_regrant_id", {5'd0, mh_id}, 8'd1);
      check("mh_regrant_tmo", {7'd0, mh_tmo}, 8'd0);
      tick();
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("mh_done_at_limit_grant", mh_grant, 8'h00);
      check("mh_done_at_limit_tmo", {7'd0, mh_tmo}, 8'd0);

      // Done and request drop together: one release, no timeout, ptr moves to 3.
      do_reset();
      req = 8'h08;
      tick();
      check("dd_id", {5'd0, rr_id}, 8'd3);
      req  = 8'h00;
      done = 1'b1;
      tick();
      done = 1'b0;
      check("dd_rel_vld", {7'd0, rr_vld}, 8'd0);
      check("dd_rel_tmo", {7'd0, rr_tmo}, 8'd0);
      req = 8'h09;
      tick();
      check("dd_next_id", {5'd0, rr_id}, 8'd0);
      check("dd_next_grant", rr_grant, 8'h01);

      // No preemption by a higher request arriving mid-tenure.
      do_reset();
      req = 8'h10;
      tick();
      check("np_id", {5'd0, rr_id}, 8'd4);
      req = 8'h90;
      tick();
      check("np_hold1", rr_grant, 8'h10);
      tick();
      check("np_hold2", rr_grant, 8'h10);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("np_rel_vld", {7'd0, rr_vld}, 8'd0);
      tick();
      check("np_next_id", {5'd0, rr_id}, 8'd7);
      check("np_next_grant", rr_grant, 8'h80);

      // Asynchronous reset between edges while grant=8'h20.
      do_reset();
      req = 8'h20;
      tick();
      check("ar_grant", rr_grant, 8'h20);
      #2;
      rst = 1'b1;
      #1;
      check("ar_grant0", rr_grant, 8'h00);
      check("ar_id0", {5'd0, rr_id}, 8'd0);
      check("ar_vld0", {7'd0, rr_vld}, 8'd0);
      check("ar_tmo0", {7'd0, rr_tmo}, 8'd0);
      #1;
      rst = 1'b0;
      req = 8'h21;
      tick();
      check("ar_next_id", {5'd0, rr_id}, 8'd5);
      check("ar_next_grant", rr_grant, 8'h20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
